// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: req/ready data-memory handshake, upstream stall, PC redirect, writeback register.
// Optional macro MEM_STAGE_TIMEOUT_EN abandons a request after TIMEOUT_CYCLES wait cycles.
module mem_access_stage #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluIn,
  input  logic [DATA_W-1:0] storeDataIn,
  input  logic [DATA_W-1:0] setValIn,
  input  logic [DATA_W-1:0] nextPcIn,
  input  logic [DATA_W-1:0] jumpPcIn,
  input  logic              doBranchIn,
  input  logic              memEnIn,
  input  logic              memWrtIn,
  input  logic              regWrtIn,
  input  logic              haltIn,
  input  logic              errIn,
  input  logic [2:0]        regWrtSrcIn,
  input  logic [2:0]        writeRegIn,
  output logic              memReq,
  output logic              memWr,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWrData,
  input  logic              memReady,
  input  logic [DATA_W-1:0] memRdData,
  output logic              stall,
  output logic              pcRedirect,
  output logic [DATA_W-1:0] pcTarget,
  output logic [DATA_W-1:0] memDataOut,
  output logic [DATA_W-1:0] aluOut,
  output logic [DATA_W-1:0] setValOut,
  output logic [DATA_W-1:0] nextPcOut,
  output logic              regWrtOut,
  output logic              haltOut,
  output logic              errOut,
  output logic [2:0]        regWrtSrcOut,
  output logic [2:0]        writeRegOut
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_reg;
  logic              halted_reg;
  logic [DATA_W-1:0] hold_addr_reg;
  logic [DATA_W-1:0] hold_data_reg;
  logic [DATA_W-1:0] hold_set_reg;
  logic [DATA_W-1:0] hold_npc_reg;
  logic              hold_wr_reg;
  logic              hold_regwrt_reg;
  logic              hold_halt_reg;
  logic              hold_err_reg;
  logic [2:0]        hold_src_reg;
  logic [2:0]        hold_wreg_reg;

  logic misalign;
  logic access;
  logic complete;
  logic abort;

  assign misalign = memEnIn & aluIn[0];
  assign access   = memEnIn & ~halted_reg & ~misalign;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == WAIT && !complete && !abort) begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  assign abort = (state_reg == WAIT) && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES));
`else
  assign abort = 1'b0;
`endif

  // In WAIT the request is driven purely from the hold registers.
  always_comb begin
    memReq    = 1'b0;
    memWr     = memWrtIn;
    memAddr   = aluIn;
    memWrData = storeDataIn;
    if (state_reg == WAIT) begin
      memReq    = ~abort;
      memWr     = hold_wr_reg;
      memAddr   = hold_addr_reg;
      memWrData = hold_data_reg;
    end else begin
      memReq    = access;
    end
  end

  assign stall      = memReq & ~memReady;
  assign complete   = memReq & memReady;
  assign pcRedirect = doBranchIn & ~stall & ~halted_reg;
  assign pcTarget   = jumpPcIn;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      halted_reg      <= 1'b0;
      hold_addr_reg   <= '0;
      hold_data_reg   <= '0;
      hold_set_reg    <= '0;
      hold_npc_reg    <= '0;
      hold_wr_reg     <= 1'b0;
      hold_regwrt_reg <= 1'b0;
      hold_halt_reg   <= 1'b0;
      hold_err_reg    <= 1'b0;
      hold_src_reg    <= '0;
      hold_wreg_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (stall) begin
            state_reg       <= WAIT;
            hold_addr_reg   <= aluIn;
            hold_data_reg   <= storeDataIn;
            hold_set_reg    <= setValIn;
            hold_npc_reg    <= nextPcIn;
            hold_wr_reg     <= memWrtIn;
            hold_regwrt_reg <= regWrtIn;
            hold_halt_reg   <= haltIn;
            hold_err_reg    <= errIn;
            hold_src_reg    <= regWrtSrcIn;
            hold_wreg_reg   <= writeRegIn;
          end else if (haltIn) begin
            halted_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (complete || abort) begin
            state_reg <= IDLE;
          end
          // An abandoned access never retires, so its halt is not honoured.
          if (complete && hold_halt_reg) begin
            halted_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      memDataOut   <= '0;
      aluOut       <= '0;
      setValOut    <= '0;
      nextPcOut    <= '0;
      regWrtOut    <= 1'b0;
      haltOut      <= 1'b0;
      errOut       <= 1'b0;
      regWrtSrcOut <= '0;
      writeRegOut  <= '0;
    end else if (stall) begin
      regWrtOut <= 1'b0;
      haltOut   <= 1'b0;
      errOut    <= 1'b0;
    end else if (abort) begin
      regWrtOut <= 1'b0;
      haltOut   <= 1'b0;
      errOut    <= 1'b1;
    end else if (state_reg == WAIT) begin
      aluOut       <= hold_addr_reg;
      setValOut    <= hold_set_reg;
      nextPcOut    <= hold_npc_reg;
      regWrtOut    <= hold_regwrt_reg;
      haltOut      <= hold_halt_reg;
      errOut       <= hold_err_reg;
      regWrtSrcOut <= hold_src_reg;
      writeRegOut  <= hold_wreg_reg;
      if (!hold_wr_reg) begin
        memDataOut <= memRdData;
      end
    end else begin
      aluOut       <= aluIn;
      setValOut    <= setValIn;
      nextPcOut    <= nextPcIn;
      regWrtOut    <= regWrtIn & ~misalign & ~halted_reg;
      haltOut      <= haltIn;
      errOut       <= errIn | misalign;
      regWrtSrcOut <= regWrtSrcIn;
      writeRegOut  <= writeRegIn;
      if (access && !memWrtIn) begin
        memDataOut <= memRdData;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of instructions with a scoreboard queue, plus reset/timeout sequences.
module tb_mem_access_stage;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] alu, sdata, setv, npc, jpc, rd;
    logic          branch, mem_en, mem_wrt, reg_wrt, halt, err;
    logic [2:0]    src, wreg;
    int            wait_n;
    logic          exp_req, exp_regwrt, exp_err, exp_halt, exp_redirect;
    logic [DW-1:0] exp_memdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] aluIn, storeDataIn, setValIn, nextPcIn, jumpPcIn;
  logic          doBranchIn, memEnIn, memWrtIn, regWrtIn, haltIn, errIn;
  logic [2:0]    regWrtSrcIn, writeRegIn;
  logic          memReq, memWr, memReady, stall, pcRedirect;
  logic [DW-1:0] memAddr, memWrData, memRdData, pcTarget;
  logic [DW-1:0] memDataOut, aluOut, setValOut, nextPcOut;
  logic          regWrtOut, haltOut, errOut;
  logic [2:0]    regWrtSrcOut, writeRegOut;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .aluIn(aluIn), .storeDataIn(storeDataIn), .setValIn(setValIn), .nextPcIn(nextPcIn),
    .jumpPcIn(jumpPcIn), .doBranchIn(doBranchIn), .memEnIn(memEnIn), .memWrtIn(memWrtIn),
    .regWrtIn(regWrtIn), .haltIn(haltIn), .errIn(errIn), .regWrtSrcIn(regWrtSrcIn),
    .writeRegIn(writeRegIn), .memReq(memReq), .memWr(memWr), .memAddr(memAddr),
    .memWrData(memWrData), .memReady(memReady), .memRdData(memRdData), .stall(stall),
    .pcRedirect(pcRedirect), .pcTarget(pcTarget), .memDataOut(memDataOut), .aluOut(aluOut),
    .setValOut(setValOut), .nextPcOut(nextPcOut), .regWrtOut(regWrtOut), .haltOut(haltOut),
    .errOut(errOut), .regWrtSrcOut(regWrtSrcOut), .writeRegOut(writeRegOut)
  );

  int   checks = 0;
  int   failures = 0;
  vec_t exp_q[$];
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(
      input logic [DW-1:0] alu, sdata, setv, npc, jpc,
      input logic branch, mem_en, mem_wrt, reg_wrt, halt, err,
      input logic [2:0] src, wreg,
      input int wait_n, input logic [DW-1:0] rd,
      input logic exp_req, exp_regwrt, exp_err, exp_halt, exp_redirect,
      input logic [DW-1:0] exp_memdata);
    vec_t v;
    v.alu = alu; v.sdata = sdata; v.setv = setv; v.npc = npc; v.jpc = jpc;
    v.branch = branch; v.mem_en = mem_en; v.mem_wrt = mem_wrt; v.reg_wrt = reg_wrt;
    v.halt = halt; v.err = err; v.src = src; v.wreg = wreg; v.wait_n = wait_n; v.rd = rd;
    v.exp_req = exp_req; v.exp_regwrt = exp_regwrt; v.exp_err = exp_err;
    v.exp_halt = exp_halt; v.exp_redirect = exp_redirect; v.exp_memdata = exp_memdata;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    aluIn = v.alu; storeDataIn = v.sdata; setValIn = v.setv; nextPcIn = v.npc;
    jumpPcIn = v.jpc; doBranchIn = v.branch; memEnIn = v.mem_en; memWrtIn = v.mem_wrt;
    regWrtIn = v.reg_wrt; haltIn = v.halt; errIn = v.err;
    regWrtSrcIn = v.src; writeRegIn = v.wreg;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    int   k;
    int   exp_stalls;
    @(negedge clk);
    drive(v);
    memReady  = (v.wait_n == 0);
    memRdData = v.rd;
    exp_q.push_back(v);
    exp_stalls = v.exp_req ? v.wait_n : 0;
    #1;
    chk($sformatf("v%0d memReq", idx), memReq, v.exp_req);
    if (v.exp_req) begin
      chk($sformatf("v%0d memAddr", idx), memAddr, v.alu);
      chk($sformatf("v%0d memWr", idx), memWr, v.mem_wrt);
      if (v.mem_wrt) chk($sformatf("v%0d memWrData", idx), memWrData, v.sdata);
    end
    k = 0;
    while (stall === 1'b1 && k < 50) begin
      chk($sformatf("v%0d redirect_in_stall", idx), pcRedirect, 1'b0);
      chk($sformatf("v%0d memAddr_held", idx), memAddr, v.alu);
      @(posedge clk); #1;
      chk($sformatf("v%0d bubble_regWrt", idx), regWrtOut, 1'b0);
      chk($sformatf("v%0d bubble_halt", idx), haltOut, 1'b0);
      chk($sformatf("v%0d bubble_err", idx), errOut, 1'b0);
      @(negedge clk);
      k++;
      memReady = (k == v.wait_n);
      #1;
    end
    chk($sformatf("v%0d stall_cycles", idx), k, exp_stalls);
    chk($sformatf("v%0d pcRedirect", idx), pcRedirect, v.exp_redirect);
    if (v.exp_redirect) chk($sformatf("v%0d pcTarget", idx), pcTarget, v.jpc);
    @(posedge clk); #1;
    memReady = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("v%0d aluOut", idx), aluOut, e.alu);
    chk($sformatf("v%0d setValOut", idx), setValOut, e.setv);
    chk($sformatf("v%0d nextPcOut", idx), nextPcOut, e.npc);
    chk($sformatf("v%0d memDataOut", idx), memDataOut, e.exp_memdata);
    chk($sformatf("v%0d regWrtOut", idx), regWrtOut, e.exp_regwrt);
    chk($sformatf("v%0d haltOut", idx), haltOut, e.exp_halt);
    chk($sformatf("v%0d errOut", idx), errOut, e.exp_err);
    chk($sformatf("v%0d regWrtSrcOut", idx), regWrtSrcOut, e.src);
    chk($sformatf("v%0d writeRegOut", idx), writeRegOut, e.wreg);
    $display("vec %0d alu=0x%04h stalls=%0d memDataOut=0x%04h regWrtOut=%0b errOut=%0b",
             idx, v.alu, k, memDataOut, regWrtOut, errOut);
  endtask

  task automatic check_regs_zero(input string tag);
    chk({tag, " memDataOut"}, memDataOut, '0);
    chk({tag, " aluOut"}, aluOut, '0);
    chk({tag, " setValOut"}, setValOut, '0);
    chk({tag, " nextPcOut"}, nextPcOut, '0);
    chk({tag, " regWrtOut"}, regWrtOut, 1'b0);
    chk({tag, " haltOut"}, haltOut, 1'b0);
    chk({tag, " errOut"}, errOut, 1'b0);
    chk({tag, " regWrtSrcOut"}, regWrtSrcOut, '0);
    chk({tag, " writeRegOut"}, writeRegOut, '0);
    chk({tag, " memReq"}, memReq, 1'b0);
    chk({tag, " stall"}, stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t zero_v;
    zero_v = mk('0, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, '0, 0, 0, 0, 0, 0, '0);
    //          alu       sdata     setv      npc       jpc       br me mw rw h  e  src   wreg  wt rd        rq rw er ha rd memdata
    vecs[0]  = mk(16'h0005, 16'h0000, 16'h0001, 16'h0102, 16'h0000, 0, 0, 0, 1, 0, 0, 3'd2, 3'd3, 0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
    vecs[1]  = mk(16'h0040, 16'h0000, 16'h0000, 16'h0104, 16'h0000, 0, 1, 0, 1, 0, 0, 3'd1, 3'd1, 3, 16'hBEEF, 1, 1, 0, 0, 0, 16'hBEEF);
    vecs[2]  = mk(16'h0010, 16'h1234, 16'h0000, 16'h0106, 16'h0000, 0, 1, 1, 0, 0, 0, 3'd0, 3'd0, 0, 16'hDEAD, 1, 0, 0, 0, 0, 16'hBEEF);
    vecs[3]  = mk(16'h0011, 16'h0000, 16'h0000, 16'h0108, 16'h0000, 0, 1, 0, 1, 0, 0, 3'd1, 3'd2, 0, 16'hCAFE, 0, 0, 1, 0, 0, 16'hBEEF);
    vecs[4]  = mk(16'h0000, 16'h0000, 16'h0000, 16'h010A, 16'h0200, 1, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'hBEEF);
    vecs[5]  = mk(16'h0020, 16'h0000, 16'h0000, 16'h010C, 16'h0300, 1, 1, 0, 1, 0, 0, 3'd1, 3'd4, 2, 16'h5555, 1, 1, 0, 0, 1, 16'h5555);
    vecs[6]  = mk(16'h0007, 16'h0000, 16'h0001, 16'h010E, 16'h0000, 0, 0, 0, 1, 0, 1, 3'd2, 3'd5, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h5555);
    vecs[7]  = mk(16'h0030, 16'h0000, 16'h0000, 16'h0110, 16'h0000, 0, 1, 0, 1, 0, 0, 3'd1, 3'd6, 0, 16'h0A0A, 1, 1, 0, 0, 0, 16'h0A0A);
    vecs[8]  = mk(16'h0044, 16'h4321, 16'h0000, 16'h0112, 16'h0000, 0, 1, 1, 0, 0, 0, 3'd0, 3'd0, 1, 16'h9999, 1, 0, 0, 0, 0, 16'h0A0A);
    vecs[9]  = mk(16'h0000, 16'h0000, 16'h0000, 16'h0114, 16'h0000, 0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0A0A);
    vecs[10] = mk(16'h0050, 16'h0000, 16'h0000, 16'h0116, 16'h0400, 1, 1, 0, 1, 0, 0, 3'd1, 3'd7, 0, 16'h7777, 0, 0, 0, 0, 0, 16'h0A0A);

    // Reset with busy-looking (non-memory, non-branch) inputs so the zeros must come from reset.
    rst = 1'b0;
    drive(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1, 1, 1, 3'd7, 3'd7,
             0, 16'hFFFF, 0, 0, 0, 0, 0, '0));
    memReady = 1'b1; memRdData = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check_regs_zero("reset");
    chk("reset pcRedirect", pcRedirect, 1'b0);
    @(negedge clk);
    drive(zero_v); memReady = 1'b0; memRdData = '0;
    rst = 1'b1;

    for (int i = 0; i < 11; i++) apply(vecs[i], i);

    // Plain reset pulse clears the sticky halt.
    @(negedge clk);
    rst = 1'b0; drive(zero_v);
    @(negedge clk);
    rst = 1'b1;

    // Reset while a load sits in WAIT; an outstanding memReady must be ignored.
    drive(mk(16'h0060, 16'h0000, 16'h0003, 16'h0118, 16'h0000, 0, 1, 0, 1, 0, 0, 3'd1, 3'd1,
             0, 16'h0000, 0, 0, 0, 0, 0, '0));
    memReady = 1'b0; memRdData = 16'h7777;
    @(posedge clk);
    @(negedge clk); #1;
    chk("rstwait memReq", memReq, 1'b1);
    chk("rstwait stall", stall, 1'b1);
    rst = 1'b0; memEnIn = 1'b0; regWrtIn = 1'b0; memReady = 1'b1;
    @(posedge clk); #1;
    check_regs_zero("rstwait");
    @(negedge clk);
    rst = 1'b1; memReady = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready memDataOut", memDataOut, 16'h0000);
    chk("idle_ready memReq", memReq, 1'b0);
    memReady = 1'b0;
    $display("seq reset_in_wait done");

    apply(mk(16'h0062, 16'h0000, 16'h0000, 16'h0120, 16'h0000, 0, 1, 0, 1, 0, 0, 3'd1, 3'd2,
             1, 16'h1357, 1, 1, 0, 0, 0, 16'h1357), 11);

`ifdef MEM_STAGE_TIMEOUT_EN
    begin : timeout_seq
      int n;
      @(negedge clk);
      drive(mk(16'h0070, 16'h0000, 16'h0000, 16'h0122, 16'h0000, 0, 1, 0, 1, 0, 0, 3'd1, 3'd3,
               0, 16'h0000, 0, 0, 0, 0, 0, '0));
      memReady = 1'b0;
      n = 0;
      #1;
      while (memReq === 1'b1 && n < 40) begin
        n++;
        @(negedge clk); #1;
      end
      chk("timeout memReq_cycles", n, 16);
      chk("timeout stall", stall, 1'b0);
      @(posedge clk); #1;
      chk("timeout errOut", errOut, 1'b1);
      chk("timeout regWrtOut", regWrtOut, 1'b0);
      @(negedge clk);
      memEnIn = 1'b0;
      $display("seq timeout req_cycles=%0d", n);
    end
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
